// File: rtl/io_responder.sv
// Memory-mapped I/O responder: decodes the 0x3xxxx window, owns the UART TX/RX FIFOs,
// the free-running cycle counter and the sticky program-stop flag.
module io_responder #(
   parameter int TX_DEPTH    = 16,
   parameter int RX_DEPTH    = 16,
   parameter int FULL_MARGIN = 2
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic [31:0] cpu_a_in,
   input  logic [7:0]  cpu_dout_in,
   input  logic        cpu_wr_in,
   output logic [7:0]  cpu_din_out,
   output logic        io_buffer_full,
   input  logic [7:0]  ram_dout_in,
   output logic        tx_valid_out,
   output logic [7:0]  tx_data_out,
   input  logic        tx_ready_in,
   input  logic        rx_push_in,
   input  logic [7:0]  rx_data_in,
   output logic        program_stop_out,
   output logic        tx_overflow_out,
   output logic        rx_overflow_out
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_DEPTH);
   localparam logic [TX_AW:0] TX_HIGH = (TX_AW+1)'(TX_DEPTH - FULL_MARGIN);
   localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_DEPTH);

   logic [7:0]       tx_mem [TX_DEPTH];
   logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [TX_AW:0]   tx_count;
   logic [7:0]       rx_mem [RX_DEPTH];
   logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [RX_AW:0]   rx_count;
   logic [31:0]      cycle_cnt, snapshot;
   logic             io_rd_q;
   logic [7:0]       io_data_q, rd_data, tx_wdata;
   logic             io_sel, io_rd, io_wr;
   logic [2:0]       off;
   logic             tx_push_req, tx_push, tx_pop, tx_full;
   logic             rx_push, rx_pop, rx_full, rx_empty;
   logic             unused_addr;

   assign unused_addr = ^{cpu_a_in[31:18], cpu_a_in[15:3]};

   assign io_sel = (cpu_a_in[17:16] == 2'b11);
   assign off    = cpu_a_in[2:0];
   assign io_rd  = rdy_in & io_sel & ~cpu_wr_in;
   assign io_wr  = rdy_in & io_sel & cpu_wr_in;

   // Only the first stop write queues its 0x00 marker byte.
   assign tx_push_req = io_wr & (((off == 3'd0) & (cpu_dout_in != 8'h00)) |
                                 ((off == 3'd4) & ~program_stop_out));
   assign tx_wdata    = (off == 3'd4) ? 8'h00 : cpu_dout_in;
   assign tx_full     = (tx_count == TX_FULL);
   assign tx_valid_out = (tx_count != '0);
   assign tx_pop      = tx_valid_out & tx_ready_in;
   assign tx_push     = tx_push_req & (~tx_full | tx_pop);
   assign tx_data_out = tx_valid_out ? tx_mem[tx_rd_ptr] : 8'h00;
   assign io_buffer_full = (tx_count >= TX_HIGH);

   assign rx_full  = (rx_count == RX_FULL);
   assign rx_empty = (rx_count == '0);
   assign rx_pop   = io_rd & (off == 3'd0) & ~rx_empty;
   assign rx_push  = rx_push_in & (~rx_full | rx_pop);

   assign cpu_din_out = io_rd_q ? io_data_q : ram_dout_in;

   always_comb begin
      rd_data = 8'h00;
      case (off)
         3'd0:    rd_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
         3'd4:    rd_data = cycle_cnt[7:0];
         3'd5:    rd_data = snapshot[15:8];
         3'd6:    rd_data = snapshot[23:16];
         3'd7:    rd_data = snapshot[31:24];
         default: rd_data = 8'h00;
      endcase
   end

   // Storage arrays carry no reset; validity is tracked by the counts.
   always_ff @(posedge clk_in) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= tx_wdata;
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_data_in;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         tx_wr_ptr        <= '0;
         tx_rd_ptr        <= '0;
         tx_count         <= '0;
         rx_wr_ptr        <= '0;
         rx_rd_ptr        <= '0;
         rx_count         <= '0;
         cycle_cnt        <= '0;
         snapshot         <= '0;
         io_rd_q          <= 1'b0;
         io_data_q        <= 8'h00;
         program_stop_out <= 1'b0;
         tx_overflow_out  <= 1'b0;
         rx_overflow_out  <= 1'b0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
         io_rd_q   <= io_rd;
         if (io_rd) begin
            io_data_q <= rd_data;
            if (off == 3'd4) snapshot <= cycle_cnt;
         end
         if (io_wr && off == 3'd4) program_stop_out <= 1'b1;

         if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + (TX_AW+1)'(1);
            2'b01:   tx_count <= tx_count - (TX_AW+1)'(1);
            default: tx_count <= tx_count;
         endcase
         if (tx_push_req && !tx_push) tx_overflow_out <= 1'b1;

         if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + (RX_AW+1)'(1);
            2'b01:   rx_count <= rx_count - (RX_AW+1)'(1);
            default: rx_count <= rx_count;
         endcase
         if (rx_push_in && !rx_push) rx_overflow_out <= 1'b1;
      end
   end

endmodule

// File: tb/tb_io_responder.sv
// Directed self-checking bench for io_responder with hand-computed expectations.
module tb_io_responder;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        rdy_in;
   logic [31:0] cpu_a_in;
   logic [7:0]  cpu_dout_in;
   logic        cpu_wr_in;
   logic [7:0]  cpu_din_out;
   logic        io_buffer_full;
   logic [7:0]  ram_dout_in;
   logic        tx_valid_out;
   logic [7:0]  tx_data_out;
   logic        tx_ready_in;
   logic        rx_push_in;
   logic [7:0]  rx_data_in;
   logic        program_stop_out;
   logic        tx_overflow_out;
   logic        rx_overflow_out;

   int checkCount = 0;
   int errorCount = 0;

   io_responder dut (
      .clk_in           (clk_in),
      .rst_n_in         (rst_n_in),
      .rdy_in           (rdy_in),
      .cpu_a_in         (cpu_a_in),
      .cpu_dout_in      (cpu_dout_in),
      .cpu_wr_in        (cpu_wr_in),
      .cpu_din_out      (cpu_din_out),
      .io_buffer_full   (io_buffer_full),
      .ram_dout_in      (ram_dout_in),
      .tx_valid_out     (tx_valid_out),
      .tx_data_out      (tx_data_out),
      .tx_ready_in      (tx_ready_in),
      .rx_push_in       (rx_push_in),
      .rx_data_in       (rx_data_in),
      .program_stop_out (program_stop_out),
      .tx_overflow_out  (tx_overflow_out),
      .rx_overflow_out  (rx_overflow_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One bus request held across a single rising edge; returns #1 after that edge.
   task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [7:0] data);
      rdy_in      = 1'b1;
      cpu_a_in    = addr;
      cpu_wr_in   = wr;
      cpu_dout_in = data;
      @(posedge clk_in);
      #1;
      rdy_in    = 1'b0;
      cpu_wr_in = 1'b0;
   endtask

   task automatic rxPush(input logic [7:0] data);
      rx_push_in = 1'b1;
      rx_data_in = data;
      @(posedge clk_in);
      #1;
      rx_push_in = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n_in = 1'b0;
      rdy_in = 1'b0; cpu_a_in = '0; cpu_dout_in = '0; cpu_wr_in = 1'b0;
      ram_dout_in = 8'hC3; tx_ready_in = 1'b0; rx_push_in = 1'b0; rx_data_in = '0;
      tick(3);

      // Reset state
      checkOutput("rst_din_ram", {24'd0, cpu_din_out}, 32'hC3);
      checkOutput("rst_tx_valid", {31'd0, tx_valid_out}, 32'd0);
      checkOutput("rst_tx_data", {24'd0, tx_data_out}, 32'd0);
      checkOutput("rst_buf_full", {31'd0, io_buffer_full}, 32'd0);
      checkOutput("rst_stop", {31'd0, program_stop_out}, 32'd0);
      checkOutput("rst_ovf", {30'd0, tx_overflow_out, rx_overflow_out}, 32'd0);
      rst_n_in = 1'b1;

      // Counter: 10 edges after release, the read captures 10
      tick(10);
      applyStimulus(32'h30004, 1'b0, 8'h00);
      checkOutput("cnt_b4", {24'd0, cpu_din_out}, 32'h0A);
      for (int i = 5; i < 8; i++) begin
         applyStimulus(32'h30000 + i, 1'b0, 8'h00);
         checkOutput($sformatf("cnt_b%0d", i), {24'd0, cpu_din_out}, 32'h00);
      end

      // TX writes; zero data is not queued
      applyStimulus(32'h30000, 1'b1, 8'h41);
      applyStimulus(32'h30000, 1'b1, 8'h00);
      applyStimulus(32'h30000, 1'b1, 8'h42);
      checkOutput("tx_valid_2", {31'd0, tx_valid_out}, 32'd1);
      tx_ready_in = 1'b1;
      checkOutput("tx_head_41", {24'd0, tx_data_out}, 32'h41);
      tick(1);
      checkOutput("tx_head_42", {24'd0, tx_data_out}, 32'h42);
      tick(1);
      checkOutput("tx_drained", {31'd0, tx_valid_out}, 32'd0);
      tx_ready_in = 1'b0;

      // Near-full threshold and overflow
      for (int i = 1; i <= 17; i++) begin
         applyStimulus(32'h30000, 1'b1, 8'(i));
         if (i == 13) checkOutput("full_after13", {31'd0, io_buffer_full}, 32'd0);
         if (i == 14) checkOutput("full_after14", {31'd0, io_buffer_full}, 32'd1);
         if (i == 16) checkOutput("ovf_after16", {31'd0, tx_overflow_out}, 32'd0);
      end
      checkOutput("ovf_after17", {31'd0, tx_overflow_out}, 32'd1);
      tx_ready_in = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         checkOutput($sformatf("drain_%0d", i), {24'd0, tx_data_out}, 32'(i));
         tick(1);
      end
      checkOutput("drain_empty", {31'd0, tx_valid_out}, 32'd0);
      tx_ready_in = 1'b0;

      // RX path, one-cycle read latency
      rxPush(8'h31);
      rxPush(8'h32);
      applyStimulus(32'h30000, 1'b0, 8'h00);
      checkOutput("rx_rd1", {24'd0, cpu_din_out}, 32'h31);
      applyStimulus(32'h30000, 1'b0, 8'h00);
      checkOutput("rx_rd2", {24'd0, cpu_din_out}, 32'h32);
      applyStimulus(32'h30000, 1'b0, 8'h00);
      checkOutput("rx_rd_empty", {24'd0, cpu_din_out}, 32'h00);

      // rdy low: request ignored, RAM data passes, byte stays queued
      rxPush(8'h55);
      ram_dout_in = 8'hA5;
      cpu_a_in = 32'h30000; cpu_wr_in = 1'b0; rdy_in = 1'b0;
      tick(1);
      checkOutput("rdy0_passthru", {24'd0, cpu_din_out}, 32'hA5);
      applyStimulus(32'h30000, 1'b0, 8'h00);
      checkOutput("rdy0_no_pop", {24'd0, cpu_din_out}, 32'h55);
      applyStimulus(32'h30000, 1'b0, 8'h00);
      checkOutput("rdy0_count1", {24'd0, cpu_din_out}, 32'h00);

      // RX overflow on 17th push into an empty FIFO
      for (int i = 0; i < 17; i++) begin
         rxPush(8'h60 + 8'(i));
         if (i == 15) checkOutput("rx_ovf_16", {31'd0, rx_overflow_out}, 32'd0);
      end
      checkOutput("rx_ovf_17", {31'd0, rx_overflow_out}, 32'd1);
      applyStimulus(32'h30000, 1'b0, 8'h00);
      checkOutput("rx_ovf_head", {24'd0, cpu_din_out}, 32'h60);

      // Stop flag, single marker byte
      applyStimulus(32'h30004, 1'b1, 8'h99);
      applyStimulus(32'h30004, 1'b1, 8'h12);
      checkOutput("stop_set", {31'd0, program_stop_out}, 32'd1);
      checkOutput("stop_marker_v", {31'd0, tx_valid_out}, 32'd1);
      checkOutput("stop_marker_d", {24'd0, tx_data_out}, 32'h00);
      tx_ready_in = 1'b1;
      tick(1);
      checkOutput("stop_one_byte", {31'd0, tx_valid_out}, 32'd0);
      tx_ready_in = 1'b0;

      // RAM passthrough
      ram_dout_in = 8'h5A;
      applyStimulus(32'h00100, 1'b0, 8'h00);
      checkOutput("ram_read", {24'd0, cpu_din_out}, 32'h5A);

      // Reset mid-stream clears everything immediately
      for (int i = 0; i < 5; i++) applyStimulus(32'h30000, 1'b1, 8'h70 + 8'(i));
      checkOutput("pre_rst_valid", {31'd0, tx_valid_out}, 32'd1);
      rst_n_in = 1'b0;
      #1;
      checkOutput("mid_rst_valid", {31'd0, tx_valid_out}, 32'd0);
      checkOutput("mid_rst_flags", {29'd0, program_stop_out, tx_overflow_out, rx_overflow_out}, 32'd0);
      tick(1);
      rst_n_in = 1'b1;

      // Full TX with simultaneous push and pop: no drop
      for (int i = 0; i < 16; i++) applyStimulus(32'h30000, 1'b1, 8'h20 + 8'(i));
      tx_ready_in = 1'b1;
      applyStimulus(32'h30000, 1'b1, 8'h77);
      checkOutput("full_pushpop_ovf", {31'd0, tx_overflow_out}, 32'd0);
      for (int i = 1; i < 16; i++) begin
         checkOutput($sformatf("pp_drain_%0d", i), {24'd0, tx_data_out}, 32'h20 + 32'(i));
         tick(1);
      end
      checkOutput("pp_last", {24'd0, tx_data_out}, 32'h77);
      tick(1);
      checkOutput("pp_empty", {31'd0, tx_valid_out}, 32'd0);
      tx_ready_in = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Memory-mapped I/O responder on the far side of the CPU byte bus (address, write data, write strobe, read data, `io_buffer_full`).
- Decodes the I/O window (`addr[17:16]==2'b11`) and owns the UART TX and RX byte FIFOs, the free-running cycle counter and the program-stop flag.
- Returns I/O read data one cycle after the request; non-I/O reads pass RAM read data through.
- Sits between the cpu top and the RAM/UART in the system top.

Parameters:
- `TX_DEPTH`, 16, TX FIFO entries (power of 2, ≥4).
- `RX_DEPTH`, 16, RX FIFO entries (power of 2, ≥2).
- `FULL_MARGIN`, 2, free TX slots remaining when `io_buffer_full` asserts.

Ports:
- `clk_in` in 1: system clock.
- `rst_n_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: CPU ready; low means the bus request is ignored.
- `cpu_a_in` in 32: CPU address (only bits 17:0 decoded).
- `cpu_dout_in` in 8: CPU write data.
- `cpu_wr_in` in 1: 1 = write, 0 = read.
- `cpu_din_out` out 8: read data to CPU.
- `io_buffer_full` out 1: TX FIFO near full.
- `ram_dout_in` in 8: RAM read data (RAM has 1-cycle latency).
- `tx_valid_out` out 1: TX FIFO non-empty.
- `tx_data_out` out 8: TX FIFO head byte.
- `tx_ready_in` in 1: UART accepts head byte this cycle.
- `rx_push_in` in 1: UART received-byte strobe.
- `rx_data_in` in 8: received byte.
- `program_stop_out` out 1: sticky stop flag.
- `tx_overflow_out` out 1: sticky, a TX push was dropped.
- `rx_overflow_out` out 1: sticky, an RX push was dropped.

Behaviour:
- **Reset (`rst_n_in` low, async):**
  - Both FIFOs empty, pointers and counts 0; cycle counter 0; snapshot 0.
  - `io_rd_q` 0, `io_data_q` 0; all sticky flags 0.
  - Outputs: `cpu_din_out` = `ram_dout_in` (since `io_rd_q`=0), `tx_valid_out` 0, `tx_data_out` 0, `io_buffer_full` 0.
  - Reset mid-operation discards FIFO contents; there is no partial state.
- **Request qualification:** `req = rdy_in`; `io = cpu_a_in[17:16]==2'b11`; `off = cpu_a_in[2:0]`.
- **Cycle counter:** 32-bit, +1 every cycle after reset regardless of `rdy_in`; wraps 0xFFFFFFFF→0.
- **I/O read (req, io, !wr)** sets next cycle `io_rd_q`=1 and `io_data_q` per offset:
  - `off=0`: RX non-empty → head byte, pop. RX empty → 0x00, no pop.
  - `off=4`: counter[7:0]; also snapshot ← counter.
  - `off=5,6,7`: snapshot[15:8], [23:16], [31:24]. A coherent word requires byte 4 to be read first.
  - any other offset: 0x00.
- **Non-I/O or no request:** `io_rd_q`=0 next cycle.
- **Read data path:** `cpu_din_out = io_rd_q ? io_data_q : ram_dout_in`, combinational mux on registered select. Latency is exactly 1 cycle for I/O and RAM alike.
- **I/O write (req, io, wr):**
  - `off=0`, data≠0x00: push data to TX. Data 0x00 is ignored.
  - `off=4`: set `program_stop_out` and push 0x00 to TX. Only the first stop write pushes; later ones are ignored.
  - other offsets: ignored.
- **TX FIFO:**
  - Pop when `tx_valid_out && tx_ready_in`.
  - Push and pop in the same cycle are both performed, count unchanged; allowed even when full.
  - Push when full without a pop: byte dropped, `tx_overflow_out` set.
- **`io_buffer_full`:** `tx_count >= TX_DEPTH-FULL_MARGIN`, driven from the registered count. The margin covers a write already in flight.
- **RX FIFO:**
  - Push on `rx_push_in`.
  - Simultaneous push and CPU pop when full: both performed.
  - Push when full without a pop: dropped, `rx_overflow_out` set.
- **Pointer arithmetic:** `log2(DEPTH)`-bit pointers wrapping modulo DEPTH; count register is `log2(DEPTH)+1` bits.
- **`rdy_in` low:** no pops, no pushes from the CPU side, no snapshot; `io_rd_q` ← 0. UART-side TX pop and RX push still proceed.

Test Plan:
- **Reset and idle:** reset, release, run 10 cycles, then read 0x30004..0x30007 → bytes of a counter value near 10. Byte 4 must match the cycle of the read; bytes 5–7 = 0.
- **TX writes:** writes 0x41, 0x00, 0x42 to 0x30000 with `tx_ready_in`=0 → `tx_count`=2. With `tx_ready_in`=1, `tx_data_out` presents 0x41 then 0x42, then `tx_valid_out` drops.
- **Near-full and overflow:** 14 writes with `TX_DEPTH`=16 → `io_buffer_full` rises after the 14th push. 3 more writes → 16 stored, 1 dropped, `tx_overflow_out`=1.
- **RX path:** push 0x31, 0x32 via `rx_push_in`; read 0x30000 three times → `cpu_din_out` = 0x31, 0x32, 0x00 each one cycle after the request. Then push 17 bytes into an empty FIFO → `rx_overflow_out`=1.
- **Stop and passthrough:** write any value to 0x30004 twice → `program_stop_out`=1 and exactly one 0x00 queued in TX. A RAM read at 0x00100 with `ram_dout_in`=0x5A → `cpu_din_out`=0x5A.
- **Control corner cases:** assert reset mid-stream with TX holding 5 bytes → `tx_valid_out`=0 immediately. A `rdy_in`=0 read of 0x30000 with RX non-empty → no pop, RX count unchanged.
